// File: rtl/desition_seq.sv
// Reaction-game sequencer: arms, runs the datapath timer, strobes the result register, tallies rounds.
// Latency: all outputs registered; each state transition lands on the next rising clk edge.
// Backpressure: none; stop/abort/comp are sampled every cycle and abort always wins.
module desition_seq #(
  parameter int ARM_CYC     = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 2,
  parameter int ROUNDS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       abort,
  input  logic       comp,
  output logic       timer_en,
  output logic       reg_load,
  output logic       busy,
  output logic       done,
  output logic       early_err,
  output logic       timeout,
  output logic [3:0] round_cnt,
  output logic [3:0] win_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    LOAD  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Reload values: each phase counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [19:0] ARM_LD = 20'(ARM_CYC - 1);
  localparam logic [19:0] RUN_LD = 20'(TIMEOUT_CYC - 1);
  localparam logic [19:0] GAP_LD = 20'(GAP_CYC - 1);
  localparam logic [3:0]  ROUNDS_V = 4'(ROUNDS);

  state_t      st;
  logic [19:0] cnt;
  logic [3:0]  round_nxt;
  logic [3:0]  win_nxt;

  // Saturating next values of the round and win tallies.
  always_comb begin
    round_nxt = (round_cnt == 4'd15) ? 4'd15 : round_cnt + 4'd1;
    win_nxt   = (win_cnt   == 4'd15) ? 4'd15 : win_cnt   + 4'd1;
  end

  assign state = st;
  assign busy  = (st != IDLE);

  // Game FSM with registered strobes; timer_en and reg_load are set on entry to RUN/LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= '0;
      timer_en  <= 1'b0;
      reg_load  <= 1'b0;
      done      <= 1'b0;
      early_err <= 1'b0;
      timeout   <= 1'b0;
      round_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      timer_en <= 1'b0;
      reg_load <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        // Counts and flags survive an abort; only the sequencing is dropped.
        st <= IDLE;
      end else begin
        case (st)
          IDLE: begin
            if (start) begin
              round_cnt <= '0;
              win_cnt   <= '0;
              early_err <= 1'b0;
              timeout   <= 1'b0;
              cnt       <= ARM_LD;
              st        <= ARM;
            end
          end
          ARM: begin
            if (stop) begin
              early_err <= 1'b1;
              done      <= 1'b1;
              st        <= IDLE;
            end else if (cnt == 20'd0) begin
              cnt      <= RUN_LD;
              timer_en <= 1'b1;
              st       <= RUN;
            end else begin
              cnt <= cnt - 20'd1;
            end
          end
          RUN: begin
            if (stop) begin
              // A stop on the final RUN cycle still counts as a player stop.
              cnt <= GAP_LD;
              st  <= GAP;
            end else if (cnt == 20'd0) begin
              timeout <= 1'b1;
              cnt     <= GAP_LD;
              st      <= GAP;
            end else begin
              cnt      <= cnt - 20'd1;
              timer_en <= 1'b1;
            end
          end
          GAP: begin
            if (cnt == 20'd0) begin
              reg_load <= 1'b1;
              st       <= LOAD;
            end else begin
              cnt <= cnt - 20'd1;
            end
          end
          LOAD: begin
            st <= CHECK;
          end
          CHECK: begin
            round_cnt <= round_nxt;
            if (comp) begin
              win_cnt <= win_nxt;
            end
            if (round_nxt == ROUNDS_V) begin
              done <= 1'b1;
              st   <= DONE;
            end else begin
              // Timeout reports only the most recent round.
              timeout <= 1'b0;
              cnt     <= ARM_LD;
              st      <= ARM;
            end
          end
          DONE: begin
            st <= IDLE;
          end
          default: begin
            st <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_desition_seq.sv
module tb_desition_seq;

  localparam int ARM_CYC     = 8;
  localparam int TIMEOUT_CYC = 50;
  localparam int GAP_CYC     = 2;
  localparam int ROUNDS      = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       abort;
  logic       comp;
  logic       timer_en;
  logic       reg_load;
  logic       busy;
  logic       done;
  logic       early_err;
  logic       timeout;
  logic [3:0] round_cnt;
  logic [3:0] win_cnt;
  logic [2:0] state;

  int n_cmp;
  int n_bad;
  int te_cnt;
  int rl_cnt;
  int dn_cnt;

  desition_seq #(
    .ARM_CYC    (ARM_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC),
    .ROUNDS     (ROUNDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .abort    (abort),
    .comp     (comp),
    .timer_en (timer_en),
    .reg_load (reg_load),
    .busy     (busy),
    .done     (done),
    .early_err(early_err),
    .timeout  (timeout),
    .round_cnt(round_cnt),
    .win_cnt  (win_cnt),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1ns after the edge, tallying strobe cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (timer_en) te_cnt++;
    if (reg_load) rl_cnt++;
    if (done)     dn_cnt++;
  endtask

  // Steps until timer_en is seen; n = steps taken, or -1 if it never rises.
  task automatic wait_te(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (timer_en) begin
        n = i;
        break;
      end
    end
  endtask

  // Steps until reg_load is seen; n = steps taken, or -1 if it never pulses.
  task automatic wait_rl(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (reg_load) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; comp = 1'b0;
    #12;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if ({timer_en, reg_load, done, early_err, timeout} !== 5'b0) begin
      n_bad++; $display("FAIL rst_flags: got %05b want 00000", {timer_en, reg_load, done, early_err, timeout});
    end
    n_cmp++; if ({round_cnt, win_cnt} !== 8'h00) begin
      n_bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", round_cnt, win_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_no_start: got %0d want 0", state); end
  endtask

  task automatic test_full_game();
    int te0, rl0, dn0, n;
    logic [3:0] exp_win;
    te0 = te_cnt; rl0 = rl_cnt; dn0 = dn_cnt;
    exp_win = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (state !== 3'd1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL game_arm: got state %0d busy %0b want 1 1", state, busy);
    end
    for (int r = 0; r < 3; r++) begin
      wait_te(n);
      n_cmp++; if (n !== ARM_CYC) begin n_bad++; $display("FAIL game_arm_len r%0d: got %0d want %0d", r, n, ARM_CYC); end
      for (int i = 1; i < 20; i++) step();
      stop = 1'b1; comp = (r != 1); step(); stop = 1'b0;
      if (r != 1) exp_win = exp_win + 4'd1;
      wait_rl(n);
      n_cmp++; if (n + 1 !== GAP_CYC + 1) begin
        n_bad++; $display("FAIL game_load_lat r%0d: got %0d want %0d", r, n + 1, GAP_CYC + 1);
      end
      step();
      step();
      n_cmp++; if (round_cnt !== 4'(r + 1) || win_cnt !== exp_win) begin
        n_bad++; $display("FAIL game_counts r%0d: got %0d/%0d want %0d/%0d", r, round_cnt, win_cnt, r + 1, exp_win);
      end
      if (r < 2) begin
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL game_rearm r%0d: got %0d want 1", r, state); end
      end else begin
        n_cmp++; if (state !== 3'd6 || done !== 1'b1) begin
          n_bad++; $display("FAIL game_done: got state %0d done %0b want 6 1", state, done);
        end
      end
    end
    step();
    n_cmp++; if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL game_end: got state %0d done %0b busy %0b want 0 0 0", state, done, busy);
    end
    n_cmp++; if (te_cnt - te0 !== 60) begin n_bad++; $display("FAIL game_te_cycles: got %0d want 60", te_cnt - te0); end
    n_cmp++; if (rl_cnt - rl0 !== 3) begin n_bad++; $display("FAIL game_loads: got %0d want 3", rl_cnt - rl0); end
    n_cmp++; if (dn_cnt - dn0 !== 1) begin n_bad++; $display("FAIL game_done_pulses: got %0d want 1", dn_cnt - dn0); end
  endtask

  task automatic test_early_stop();
    int te0;
    te0 = te_cnt;
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (state !== 3'd0 || early_err !== 1'b1 || done !== 1'b1) begin
      n_bad++; $display("FAIL early_stop: got state %0d err %0b done %0b want 0 1 1", state, early_err, done);
    end
    step();
    n_cmp++; if (done !== 1'b0 || early_err !== 1'b1) begin
      n_bad++; $display("FAIL early_after: got done %0b err %0b want 0 1", done, early_err);
    end
    n_cmp++; if (te_cnt !== te0) begin n_bad++; $display("FAIL early_te: got %0d want 0", te_cnt - te0); end
  endtask

  task automatic test_timeout();
    int te0, n;
    te0 = te_cnt;
    start = 1'b1; step(); start = 1'b0;
    wait_te(n);
    for (int i = 0; i < 200; i++) begin
      step();
      if (!timer_en) break;
    end
    n_cmp++; if (te_cnt - te0 !== TIMEOUT_CYC) begin
      n_bad++; $display("FAIL to_te_cycles: got %0d want %0d", te_cnt - te0, TIMEOUT_CYC);
    end
    n_cmp++; if (timeout !== 1'b1 || state !== 3'd3) begin
      n_bad++; $display("FAIL to_flag: got timeout %0b state %0d want 1 3", timeout, state);
    end
    wait_rl(n);
    n_cmp++; if (n !== GAP_CYC) begin n_bad++; $display("FAIL to_load: got %0d want %0d", n, GAP_CYC); end
    step();
    step();
    n_cmp++; if (state !== 3'd1 || timeout !== 1'b0 || round_cnt !== 4'd1) begin
      n_bad++; $display("FAIL to_rearm: got state %0d timeout %0b rounds %0d want 1 0 1", state, timeout, round_cnt);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_stop_at_timeout();
    int te0, n;
    te0 = te_cnt;
    start = 1'b1; step(); start = 1'b0;
    wait_te(n);
    for (int i = 1; i < TIMEOUT_CYC; i++) step();
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (timeout !== 1'b0 || state !== 3'd3) begin
      n_bad++; $display("FAIL same_cycle: got timeout %0b state %0d want 0 3", timeout, state);
    end
    n_cmp++; if (te_cnt - te0 !== TIMEOUT_CYC) begin
      n_bad++; $display("FAIL same_te: got %0d want %0d", te_cnt - te0, TIMEOUT_CYC);
    end
    wait_rl(n);
    n_cmp++; if (n !== GAP_CYC) begin n_bad++; $display("FAIL same_load: got %0d want %0d", n, GAP_CYC); end
    step();
    step();
    n_cmp++; if (round_cnt !== 4'd1 || state !== 3'd1) begin
      n_bad++; $display("FAIL same_round: got rounds %0d state %0d want 1 1", round_cnt, state);
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort_gap();
    int rl0, dn0, n;
    start = 1'b1; step(); start = 1'b0;
    comp = 1'b1;
    wait_te(n);
    stop = 1'b1; step(); stop = 1'b0;
    wait_rl(n);
    step();
    step();
    wait_te(n);
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL abort_pre: got %0d want 3", state); end
    rl0 = rl_cnt; dn0 = dn_cnt;
    abort = 1'b1; step(); abort = 1'b0;
    n_cmp++; if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || reg_load !== 1'b0) begin
      n_bad++; $display("FAIL abort_gap: got state %0d busy %0b done %0b load %0b want 0 0 0 0", state, busy, done, reg_load);
    end
    n_cmp++; if (round_cnt !== 4'd1 || win_cnt !== 4'd1) begin
      n_bad++; $display("FAIL abort_counts: got %0d/%0d want 1/1", round_cnt, win_cnt);
    end
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (rl_cnt !== rl0 || dn_cnt !== dn0) begin
      n_bad++; $display("FAIL abort_quiet: got loads %0d dones %0d want 0 0", rl_cnt - rl0, dn_cnt - dn0);
    end
  endtask

  task automatic test_reset_mid_round();
    int n;
    start = 1'b1; step(); start = 1'b0;
    comp = 1'b1;
    wait_te(n);
    stop = 1'b1; step(); stop = 1'b0;
    wait_rl(n);
    step();
    step();
    wait_te(n);
    n_cmp++; if (round_cnt !== 4'd1 || timer_en !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got rounds %0d te %0b want 1 1", round_cnt, timer_en);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (timer_en !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got te %0b state %0d busy %0b want 0 0 0", timer_en, state, busy);
    end
    n_cmp++; if (round_cnt !== 4'd0 || win_cnt !== 4'd0) begin
      n_bad++; $display("FAIL mid_counts: got %0d/%0d want 0/0", round_cnt, win_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL mid_idle: got %0d want 0", state); end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL mid_restart: got %0d want 1", state); end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    te_cnt = 0; rl_cnt = 0; dn_cnt = 0;
    test_reset();
    test_full_game();
    test_early_stop();
    test_timeout();
    test_stop_at_timeout();
    test_abort_gap();
    test_reset_mid_round();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/desition_seq.md
DESITION_SEQ -- requirements
Module: desition_seq

Interface
- REQ-001 SHALL have parameter ARM_CYC, default 8: cycles spent in ARM before the timer is enabled (1..255).
- REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000: maximum cycles in RUN (1..2^20-1).
- REQ-003 SHALL have parameter GAP_CYC, default 2: cycles of timer_en low before the register strobe (1..15).
- REQ-004 SHALL have parameter ROUNDS, default 3: rounds per game (1..15).
- REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
- REQ-007 SHALL have port start, input, 1: begin-game request, sampled only in IDLE.
- REQ-008 SHALL have port stop, input, 1: player stop, synchronous and already debounced.
- REQ-009 SHALL have port abort, input, 1: synchronous return to IDLE from any state.
- REQ-010 SHALL have port comp, input, 1: compare result from the measurement datapath.
- REQ-011 SHALL have port timer_en, output, 1: enable to the datapath timer input.
- REQ-012 SHALL have port reg_load, output, 1: one-cycle strobe to the datapath register input.
- REQ-013 SHALL have ports busy, done, early_err and timeout, output, 1 each: status.
- REQ-014 SHALL have ports round_cnt and win_cnt, output, 4 each: completed rounds and rounds with comp=1.
- REQ-015 SHALL have port state, output, 3: current FSM state encoding.

Function
- REQ-016 SHALL implement the FSM states IDLE=0, ARM=1, RUN=2, GAP=3, LOAD=4, CHECK=5 and DONE=6.
- REQ-017 SHALL, in IDLE with start=1, clear round_cnt, win_cnt, early_err and timeout, load the ARM counter with ARM_CYC-1, and go to ARM.
- REQ-018 SHALL, in ARM, decrement the counter each cycle and go to RUN on the cycle the counter is 0.
- REQ-019 SHALL, in ARM with stop=1, set early_err, pulse done for 1 cycle, and go to IDLE; stop has priority over the counter reaching 0.
- REQ-020 SHALL drive timer_en=1 exactly while in RUN.
- REQ-021 SHALL, in RUN with stop=1, go to GAP.
- REQ-022 SHALL, in RUN after TIMEOUT_CYC cycles without stop, set timeout and go to GAP; stop in the same cycle SHALL win and leave timeout clear.
- REQ-023 SHALL stay in GAP for GAP_CYC cycles with timer_en=0, then go to LOAD.
- REQ-024 SHALL, in LOAD, drive reg_load=1 for exactly 1 cycle, then go to CHECK.
- REQ-025 SHALL, in CHECK, sample comp and increment round_cnt, and also win_cnt if comp=1; both counts SHALL saturate at 15.
- REQ-026 SHALL, after CHECK, go to DONE if the new round_cnt equals ROUNDS, else to ARM with the counter reloaded.
- REQ-027 SHALL hold done=1 for exactly 1 cycle while in DONE, then go to IDLE.
- REQ-028 SHALL drive busy=1 in every state except IDLE.
- REQ-029 SHALL, when abort=1, go to IDLE the next cycle, force timer_en and reg_load to 0, keep the counts, and not assert done; abort has priority over all other inputs.
- REQ-030 SHALL ignore start outside IDLE and ignore stop outside ARM and RUN.
- REQ-031 SHALL clear the timeout flag when a new round enters ARM, so timeout reflects the last round only.

Reset
- REQ-032 SHALL, while rst=0, asynchronously force state to IDLE and all outputs, counters and flags to 0.
- REQ-033 SHALL leave IDLE no earlier than the first rising edge after rst deasserts, and only with start=1.
- REQ-034 SHALL abandon any round in progress when reset is asserted mid-round, and drop timer_en immediately.

Verification
- REQ-035 SHALL be checked for reset: rst=0 during RUN -> timer_en=0 at once; state=0, counts=0, busy=0.
- REQ-036 SHALL be checked for a full game: defaults, start, stop 20 cycles after RUN entry in each round, comp=1,0,1 -> timer_en high 20 cycles per round, reg_load pulses 3 times each GAP_CYC+1 cycles after stop, round_cnt=3, win_cnt=2, single done pulse.
- REQ-037 SHALL be checked for an early stop: stop 3 cycles after start -> early_err=1, done pulse, timer_en never high, state=0.
- REQ-038 SHALL be checked for timeout: TIMEOUT_CYC=50, no stop -> timer_en high exactly 50 cycles, timeout=1, then reg_load pulse.
- REQ-039 SHALL be checked for abort in GAP -> next cycle state=0, reg_load never asserted, done=0, counts unchanged.
- REQ-040 SHALL be checked for simultaneous stop and timeout on the same cycle -> timeout=0 and the round proceeds normally.
